// File: rtl/fpu_prog_loader.sv
// UART program loader: packs received bytes into little-endian words and writes them to SRAM.
// Optional checksum verification is compiled in with FPU_PROG_LOADER_CKSUM_EN.
module fpu_prog_loader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter logic [DATA_W-1:0] END_WORD = DATA_W'(32'h0000_0FFF)
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              rx_dv_i,
  input  logic [7:0]        rx_byte_i,
  input  logic              restart_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              load_done_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic              overflow_o,
  output logic              rx_drop_o,
  output logic              cksum_err_o
);

  localparam int unsigned NB  = DATA_W / 8;
  localparam int unsigned BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    StRecv,
    StCheck,
    StWrite,
    StDone,
`ifdef FPU_PROG_LOADER_CKSUM_EN
    StError,
    StCksum
`else
    StError
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              overflow_q, overflow_d;
  logic              drop_q, drop_d;
  logic [DATA_W-1:0] asm_word;
  logic              last_byte;
`ifdef FPU_PROG_LOADER_CKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              ck_phase_q, ck_phase_d;
  logic              cksum_err_q, cksum_err_d;
`endif

  always_comb begin
    asm_word = buf_q;
    asm_word[{byte_cnt_q, 3'b000} +: 8] = rx_byte_i;
  end

  assign last_byte = (byte_cnt_q == BCW'(NB - 1));

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    buf_d      = buf_q;
    word_d     = word_q;
    addr_d     = addr_q;
    count_d    = count_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
`ifdef FPU_PROG_LOADER_CKSUM_EN
    acc_d       = acc_q;
    ck_phase_d  = ck_phase_q;
    cksum_err_d = cksum_err_q;
`endif
    if (restart_i) begin
      state_d    = StRecv;
      byte_cnt_d = '0;
      addr_d     = '0;
      count_d    = '0;
      out_addr_d = '0;
      overflow_d = 1'b0;
      drop_d     = 1'b0;
`ifdef FPU_PROG_LOADER_CKSUM_EN
      acc_d       = '0;
      ck_phase_d  = 1'b0;
      cksum_err_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
`ifdef FPU_PROG_LOADER_CKSUM_EN
        StRecv, StCksum: begin
`else
        StRecv: begin
`endif
          if (rx_dv_i) begin
            buf_d = asm_word;
            if (last_byte) begin
              word_d     = asm_word;
              byte_cnt_d = '0;
              state_d    = StCheck;
`ifdef FPU_PROG_LOADER_CKSUM_EN
              ck_phase_d = (state_q == StCksum);
`endif
            end else begin
              byte_cnt_d = byte_cnt_q + BCW'(1);
            end
          end
        end
        StCheck: begin
          if (rx_dv_i) drop_d = 1'b1;
`ifdef FPU_PROG_LOADER_CKSUM_EN
          if (ck_phase_q) begin
            ck_phase_d = 1'b0;
            if (word_q == acc_q) begin
              state_d = StDone;
            end else begin
              cksum_err_d = 1'b1;
              state_d     = StError;
            end
          end else if (word_q == END_WORD) begin
            state_d = StCksum;
          end else
`else
          if (word_q == END_WORD) begin
            state_d = StDone;
          end else
`endif
          if (count_q == FULL_COUNT) begin
            overflow_d = 1'b1;
            state_d    = StError;
          end else begin
            out_addr_d = addr_q;
            out_data_d = word_q;
            state_d    = StWrite;
          end
        end
        StWrite: begin
          if (rx_dv_i) drop_d = 1'b1;
          // Saturate; the full condition is caught on the next word in CHECK.
          if (addr_q != {ADDR_W{1'b1}}) addr_d = addr_q + ADDR_W'(1);
          count_d = count_q + (ADDR_W + 1)'(1);
`ifdef FPU_PROG_LOADER_CKSUM_EN
          acc_d = acc_q + word_q;
`endif
          state_d = StRecv;
        end
        StDone, StError: ;
        default: state_d = StRecv;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= StRecv;
      byte_cnt_q <= '0;
      buf_q      <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 1'b0;
`ifdef FPU_PROG_LOADER_CKSUM_EN
      acc_q       <= '0;
      ck_phase_q  <= 1'b0;
      cksum_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      buf_q      <= buf_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
`ifdef FPU_PROG_LOADER_CKSUM_EN
      acc_q       <= acc_d;
      ck_phase_q  <= ck_phase_d;
      cksum_err_q <= cksum_err_d;
`endif
    end
  end

  assign we_o         = (state_q == StWrite);
  assign addr_o       = out_addr_q;
  assign wdata_o      = out_data_q;
  assign load_done_o  = (state_q == StDone);
  assign word_count_o = count_q;
  assign overflow_o   = overflow_q;
  assign rx_drop_o    = drop_q;
`ifdef FPU_PROG_LOADER_CKSUM_EN
  assign cksum_err_o  = cksum_err_q;
`else
  assign cksum_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_prog_loader.sv
// Self-checking bench for fpu_prog_loader (DATA_W=32, ADDR_W=2) against a word-level program model.
module tb_fpu_prog_loader;

  localparam int unsigned AW = 2;
  localparam logic [31:0] END_W = 32'h0000_0FFF;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          rx_dv = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          restart = 1'b0;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          load_done;
  logic [AW:0]   word_count;
  logic          overflow;
  logic          rx_drop;
  logic          cksum_err;

  int n_tests = 0;
  int n_fail  = 0;

  fpu_prog_loader #(.DATA_W(32), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .rx_dv_i      (rx_dv),
    .rx_byte_i    (rx_byte),
    .restart_i    (restart),
    .we_o         (we),
    .addr_o       (addr),
    .wdata_o      (wdata),
    .load_done_o  (load_done),
    .word_count_o (word_count),
    .overflow_o   (overflow),
    .rx_drop_o    (rx_drop),
    .cksum_err_o  (cksum_err)
  );

  always #5 clk = ~clk;

  // Program model: what the SRAM must see and where the load must end up.
  logic [33:0] exp_q[$];
  int          m_wc;
  logic [31:0] m_acc;
  bit          m_done, m_err, m_ov, m_drop, m_cks_err, m_ck_phase;
  int          n_writes;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_wc = 0; m_acc = '0;
    m_done = 0; m_err = 0; m_ov = 0; m_drop = 0; m_cks_err = 0; m_ck_phase = 0;
  endtask

  task automatic model_word(input logic [31:0] w, input bit dbl);
    if (m_done || m_err) return;
    if (dbl) m_drop = 1;
    if (m_ck_phase) begin
      m_ck_phase = 0;
      if (w == m_acc) m_done = 1;
      else begin m_cks_err = 1; m_err = 1; end
    end else if (w == END_W) begin
`ifdef FPU_PROG_LOADER_CKSUM_EN
      m_ck_phase = 1;
`else
      m_done = 1;
`endif
    end else if (m_wc == (1 << AW)) begin
      m_ov = 1; m_err = 1;
    end else begin
      exp_q.push_back({AW'(m_wc), w});
      m_wc++;
      m_acc += w;
    end
  endtask

  always @(negedge clk) begin
    if (rst_l && we) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_we: got addr %0h data %0h expected no write", addr, wdata);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("write_addr", 64'(addr), 64'(e[33:32]));
        chk("write_data", 64'(wdata), 64'(e[31:0]));
        n_writes++;
        last_addr = addr;
        last_data = wdata;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit dbl);
    @(posedge clk); #1;
    rx_dv = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    if (dbl) begin @(posedge clk); #1; end
    rx_dv = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit dbl);
    model_word(w, dbl);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], dbl && (k == 3));
  endtask

  // Sends three bytes, then strobes the last one and leaves the bench just after its edge.
  task automatic send_word_hold_last(input logic [31:0] w);
    model_word(w, 1'b0);
    for (int k = 0; k < 3; k++) send_byte(w[8*k +: 8], 1'b0);
    @(posedge clk); #1;
    rx_dv = 1'b1; rx_byte = w[31:24];
    @(posedge clk); #1;
    rx_dv = 1'b0;
  endtask

  task automatic pulse_restart(input bit with_dv);
    @(posedge clk); #1;
    restart = 1'b1;
    if (with_dv) begin rx_dv = 1'b1; rx_byte = 8'h99; end
    @(posedge clk); #1;
    restart = 1'b0; rx_dv = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
  endtask

  task automatic check_state(input string nm);
    @(negedge clk);
    chk({nm, "_done"},     64'(load_done),  64'(m_done));
    chk({nm, "_count"},    64'(word_count), 64'(m_wc));
    chk({nm, "_overflow"}, 64'(overflow),   64'(m_ov));
    chk({nm, "_drop"},     64'(rx_drop),    64'(m_drop));
    chk({nm, "_cksum"},    64'(cksum_err),  64'(m_cks_err));
    chk({nm, "_pending"},  64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    n_writes = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_we", 64'(we), 64'(0));
    chk("reset_addr", 64'(addr), 64'(0));
    chk("reset_wdata", 64'(wdata), 64'(0));
    check_state("reset");
    rst_l = 1'b1;
    repeat (2) @(posedge clk);

    // Basic load with write and done latency pinned.
    send_word(32'h1234_5678, 1'b0);
    send_word_hold_last(32'hDEAD_BEEF);
    @(negedge clk); chk("we_t1", 64'(we), 64'(0));
    @(negedge clk); chk("we_t2", 64'(we), 64'(1));
    repeat (3) @(posedge clk);
    send_word_hold_last(END_W);
`ifndef FPU_PROG_LOADER_CKSUM_EN
    @(negedge clk); chk("done_t1", 64'(load_done), 64'(0));
    @(negedge clk); chk("done_t2", 64'(load_done), 64'(1));
`endif
    repeat (3) @(posedge clk);
    chk("basic_writes", 64'(n_writes), 64'(2));
    chk("basic_last_addr", 64'(last_addr), 64'(1));
    chk("basic_last_data", 64'(last_data), 64'hDEAD_BEEF);
    chk("basic_count", 64'(word_count), 64'(2));
`ifndef FPU_PROG_LOADER_CKSUM_EN
    check_state("basic");
`endif

    // Restart mid-word, then a clean one-word program.
    pulse_restart(1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    pulse_restart(1'b0);
    send_word(32'hCAFE_F00D, 1'b0);
    send_word(END_W, 1'b0);
`ifndef FPU_PROG_LOADER_CKSUM_EN
    check_state("restart_mid");
`endif
    chk("restart_mid_data", 64'(last_data), 64'hCAFE_F00D);
    chk("restart_mid_addr", 64'(last_addr), 64'(0));

    // Restart coincident with a byte strobe.
    pulse_restart(1'b1);
    send_word(32'h1122_3344, 1'b0);
    send_word(END_W, 1'b0);
`ifndef FPU_PROG_LOADER_CKSUM_EN
    check_state("restart_dv");
`endif
    chk("restart_dv_data", 64'(last_data), 64'h1122_3344);

    // Byte strobed in CHECK is dropped; the word is still written.
    pulse_restart(1'b0);
    send_word(32'h0102_0304, 1'b1);
    send_word(32'h0A0B_0C0D, 1'b0);
    send_word(END_W, 1'b0);
`ifndef FPU_PROG_LOADER_CKSUM_EN
    check_state("drop");
`endif
    chk("drop_flag", 64'(rx_drop), 64'(1));

`ifdef FPU_PROG_LOADER_CKSUM_EN
    pulse_restart(1'b0);
    send_word(32'h0000_0001, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b0);
    send_word(END_W, 1'b0);
    send_word(32'h0000_0000, 1'b0);
    check_state("cksum_ok");
    chk("cksum_ok_done", 64'(load_done), 64'(1));
    pulse_restart(1'b0);
    send_word(32'h0000_0001, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b0);
    send_word(END_W, 1'b0);
    send_word(32'h0000_0001, 1'b0);
    check_state("cksum_bad");
    chk("cksum_bad_err", 64'(cksum_err), 64'(1));
`endif

    // Asynchronous reset during WRITE.
    pulse_restart(1'b0);
    send_word_hold_last(32'h5555_AAAA);
    @(negedge clk);
    @(negedge clk);
    chk("arst_we_before", 64'(we), 64'(1));
    #2 rst_l = 1'b0;
    #1 chk("arst_we_drop", 64'(we), 64'(0));
    @(posedge clk); #1;
    rst_l = 1'b1;
    model_reset();
    @(negedge clk);
    chk("arst_addr", 64'(addr), 64'(0));
    chk("arst_wdata", 64'(wdata), 64'(0));
    check_state("arst");

    // Overflow: the fifth word does not fit in four locations.
    for (int i = 0; i < 5; i++) send_word(32'h0000_0100 + 32'(i), 1'b0);
    check_state("overflow");
    chk("overflow_flag", 64'(overflow), 64'(1));
    chk("overflow_last_addr", 64'(last_addr), 64'(3));
    chk("overflow_last_data", 64'(last_data), 64'h0000_0103);
    send_word(END_W, 1'b0);
    check_state("overflow_end");
    chk("overflow_not_done", 64'(load_done), 64'(0));

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
